reg_file: RTL



---
 rtl/reg_file.sv | 49 ++++
 1 files changed

// File: rtl/reg_file.sv
// Integer register file x0..x31: two combinational read ports, one write port; x0 reads as zero.
// Latency: reads zero-cycle, writes commit on the rising clk edge.
// No backpressure. Optional REGFILE_BYPASS_EN makes a same-cycle write visible on the read ports.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic [15:0]     WrCnt
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_en;

  // Writes to x0 are dropped here so they neither change storage nor count.
  assign wr_en = WE3 && (A3 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      WrCnt <= '0;
    end else if (wr_en) begin
      regs[A3] <= WD3;
      WrCnt    <= WrCnt + 16'd1;
    end
  end

  always_comb begin
    RD1 = (A1 == '0) ? '0 : regs[A1];
    RD2 = (A2 == '0) ? '0 : regs[A2];
`ifdef REGFILE_BYPASS_EN
    // Gated by rst_n so the write-through cannot leak data while reset is held.
    if (rst_n && wr_en && (A1 == A3)) RD1 = WD3;
    if (rst_n && wr_en && (A2 == A3)) RD2 = WD3;
`endif
  end

endmodule
